// File: rtl/me_search_engine_if.sv
// rtl/me_search_engine_if.sv - control, memory and result bus of the motion estimator
interface me_search_engine_if #(
  parameter int BLK    = 16,
  parameter int RANGE  = 8,
  parameter int PIX_W  = 8,
  parameter int DIST_W = 16
);
  localparam int SW     = BLK + 2 * RANGE;
  localparam int AREF_W = $clog2(BLK * BLK);
  localparam int ASRC_W = $clog2(SW * SW);
  localparam int MV_W   = $clog2(2 * RANGE);

  logic              start_signal;
  logic              early_term_en;
  logic [AREF_W-1:0] address_ref;
  logic [PIX_W-1:0]  ref_data;
  logic [ASRC_W-1:0] address_search;
  logic [PIX_W-1:0]  search_data;
  logic              busy;
  logic              process_completed;
  logic [DIST_W-1:0] best_distance;
  logic [MV_W-1:0]   motion_vector_x;
  logic [MV_W-1:0]   motion_vector_y;

  modport master (
    output start_signal, early_term_en, ref_data, search_data,
    input  address_ref, address_search, busy, process_completed,
    input  best_distance, motion_vector_x, motion_vector_y
  );

  modport slave (
    input  start_signal, early_term_en, ref_data, search_data,
    output address_ref, address_search, busy, process_completed,
    output best_distance, motion_vector_x, motion_vector_y
  );
endinterface

// File: rtl/me_search_engine.sv
// rtl/me_search_engine.sv - full-search block-matching motion estimator
// Three-stage pipe: issue addresses, wait for memory, accumulate saturating SAD.
module me_search_engine #(
  parameter int BLK    = 16,
  parameter int RANGE  = 8,
  parameter int PIX_W  = 8,
  parameter int DIST_W = 16
) (
  input  logic clk,
  input  logic reset,
  me_search_engine_if.slave bus
);
  localparam int SW     = BLK + 2 * RANGE;
  localparam int AREF_W = $clog2(BLK * BLK);
  localparam int ASRC_W = $clog2(SW * SW);
  localparam int MV_W   = $clog2(2 * RANGE);
  localparam int PW     = $clog2(BLK);
  localparam logic [MV_W-1:0]   CMAX = MV_W'(2 * RANGE - 1);
  localparam logic [MV_W-1:0]   ROFF = MV_W'(RANGE);
  localparam logic [PW-1:0]     PMAX = PW'(BLK - 1);
  localparam logic [DIST_W-1:0] ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;

  logic [MV_W-1:0]   r_cx, r_cy, r_p1_cx, r_p1_cy, r_p2_cx, r_p2_cy;
  logic [PW-1:0]     r_r, r_c;
  logic              r_early, r_v1, r_v2;
  logic              r_p1_first, r_p1_last, r_p2_first, r_p2_last;
  logic [DIST_W-1:0] r_acc, r_best, r_best_out;
  logic [MV_W-1:0]   r_best_x, r_best_y, r_mvx, r_mvy;
  logic [AREF_W-1:0] r_addr_ref;
  logic [ASRC_W-1:0] r_addr_srch;

  logic [PIX_W-1:0]  w_ad;
  logic [DIST_W:0]   w_sum;
  logic [DIST_W-1:0] w_acc_new;
  logic              w_abandon, w_skip, w_cand_last, w_ivalid, w_iend;
  logic [MV_W-1:0]   w_ix, w_iy;
  logic [PW-1:0]     w_ir, w_ic;
  logic [AREF_W-1:0] w_aref;
  logic [ASRC_W-1:0] w_asrc;
  logic              w_busy, w_done;

  always_comb begin
    w_ad = (bus.ref_data > bus.search_data) ? bus.ref_data - bus.search_data
                                            : bus.search_data - bus.ref_data;
    w_sum = (r_p2_first ? '0 : {1'b0, r_acc}) + {{(DIST_W + 1 - PIX_W){1'b0}}, w_ad};
    w_acc_new = w_sum[DIST_W] ? ONES : w_sum[DIST_W-1:0];
    w_abandon = r_v2 && r_early && !r_p2_last && (w_acc_new >= r_best);
    // If the read in flight is already the next candidate, the issue counters are past it.
    w_skip = w_abandon && !r_p1_last;
    w_cand_last = (r_cx == CMAX) && (r_cy == CMAX);
    w_ix = r_cx;
    w_iy = r_cy;
    w_ir = r_r;
    w_ic = r_c;
    w_ivalid = (r_state == S_RUN);
    if (w_skip) begin
      w_ir = '0;
      w_ic = '0;
      w_ix = (r_cx == CMAX) ? '0 : r_cx + 1'b1;
      w_iy = (r_cx == CMAX) ? r_cy + 1'b1 : r_cy;
      if (w_cand_last) w_ivalid = 1'b0;
    end
    w_iend = (w_ix == CMAX) && (w_iy == CMAX) && (w_ir == PMAX) && (w_ic == PMAX);
    w_aref = AREF_W'(w_ir) * AREF_W'(BLK) + AREF_W'(w_ic);
    w_asrc = (ASRC_W'(w_iy) + ASRC_W'(w_ir)) * ASRC_W'(SW) + ASRC_W'(w_ix) + ASRC_W'(w_ic);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_signal) w_next = S_RUN;
      S_RUN:   if (!w_ivalid || w_iend) w_next = S_DRAIN;
      S_DRAIN: if (!r_v1 && !r_v2) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    w_done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cx <= '0; r_cy <= '0; r_r <= '0; r_c <= '0;
      r_early <= 1'b0; r_v1 <= 1'b0; r_v2 <= 1'b0;
      r_p1_first <= 1'b0; r_p1_last <= 1'b0; r_p1_cx <= '0; r_p1_cy <= '0;
      r_p2_first <= 1'b0; r_p2_last <= 1'b0; r_p2_cx <= '0; r_p2_cy <= '0;
      r_acc <= '0; r_best <= ONES; r_best_x <= '0; r_best_y <= '0;
      r_addr_ref <= '0; r_addr_srch <= '0;
      r_best_out <= ONES; r_mvx <= '0; r_mvy <= '0;
    end else begin
      if (r_state == S_IDLE && bus.start_signal) begin
        r_cx <= '0; r_cy <= '0; r_r <= '0; r_c <= '0;
        r_early <= bus.early_term_en;
        r_best <= ONES; r_best_x <= '0; r_best_y <= '0;
        r_v1 <= 1'b0; r_v2 <= 1'b0;
      end else begin
        r_v1 <= w_ivalid;
        r_v2 <= r_v1 && !w_abandon;
        r_p2_first <= r_p1_first;
        r_p2_last  <= r_p1_last;
        r_p2_cx    <= r_p1_cx;
        r_p2_cy    <= r_p1_cy;
        if (w_ivalid) begin
          r_addr_ref  <= w_aref;
          r_addr_srch <= w_asrc;
          r_p1_first  <= (w_ir == '0) && (w_ic == '0);
          r_p1_last   <= (w_ir == PMAX) && (w_ic == PMAX);
          r_p1_cx     <= w_ix;
          r_p1_cy     <= w_iy;
          r_cx <= w_ix;
          r_cy <= w_iy;
          r_r  <= w_ir;
          r_c  <= w_ic + 1'b1;
          if (w_ic == PMAX) begin
            r_c <= '0;
            r_r <= w_ir + 1'b1;
            if (w_ir == PMAX) begin
              r_r  <= '0;
              r_cx <= (w_ix == CMAX) ? '0 : w_ix + 1'b1;
              r_cy <= (w_ix == CMAX) ? w_iy + 1'b1 : w_iy;
            end
          end
        end
        if (r_v2) begin
          r_acc <= w_acc_new;
          if (r_p2_last && (w_acc_new < r_best)) begin
            r_best   <= w_acc_new;
            r_best_x <= r_p2_cx - ROFF;
            r_best_y <= r_p2_cy - ROFF;
          end
        end
      end
      if (w_next == S_DONE) begin
        r_best_out <= r_best;
        r_mvx      <= r_best_x;
        r_mvy      <= r_best_y;
      end
    end
  end

  assign bus.address_ref       = r_addr_ref;
  assign bus.address_search    = r_addr_srch;
  assign bus.busy              = w_busy;
  assign bus.process_completed = w_done;
  assign bus.best_distance     = r_best_out;
  assign bus.motion_vector_x   = r_mvx;
  assign bus.motion_vector_y   = r_mvy;
endmodule

// File: tb/tb_me_search_engine.sv
// tb/tb_me_search_engine.sv - self-checking bench for me_search_engine
// Small geometry (4x4 block, +/-2 range, 8-bit SAD) with a scoreboard fed by a search model.
module tb_me_search_engine;
  localparam int BLK    = 4;
  localparam int RANGE  = 2;
  localparam int PIX_W  = 8;
  localparam int DIST_W = 8;
  localparam int SW     = BLK + 2 * RANGE;
  localparam int NPIX   = (2 * RANGE) * (2 * RANGE) * BLK * BLK;
  localparam int LAT    = NPIX + 3;
  localparam int MAXD   = (1 << DIST_W) - 1;
  localparam int MVMASK = (2 * RANGE) - 1;

  typedef struct {
    int best;
    int mvx;
    int mvy;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [PIX_W-1:0] ref_mem  [BLK*BLK];
  logic [PIX_W-1:0] srch_mem [SW*SW];
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  me_search_engine_if #(.BLK(BLK), .RANGE(RANGE), .PIX_W(PIX_W), .DIST_W(DIST_W)) bus ();

  me_search_engine #(.BLK(BLK), .RANGE(RANGE), .PIX_W(PIX_W), .DIST_W(DIST_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.ref_data    <= ref_mem[bus.address_ref];
    bus.search_data <= srch_mem[bus.address_search];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push();
    exp_t e;
    int best = MAXD;
    int bx = 0;
    int by = 0;
    for (int cy = 0; cy < 2 * RANGE; cy++) begin
      for (int cx = 0; cx < 2 * RANGE; cx++) begin
        int acc = 0;
        for (int r = 0; r < BLK; r++) begin
          for (int c = 0; c < BLK; c++) begin
            int a = int'(ref_mem[r*BLK+c]);
            int s = int'(srch_mem[(cy+r)*SW + cx + c]);
            acc += (a > s) ? a - s : s - a;
            if (acc > MAXD) acc = MAXD;
          end
        end
        if (acc < best) begin
          best = acc;
          bx = cx - RANGE;
          by = cy - RANGE;
        end
      end
    end
    e.best = best;
    e.mvx = bx & MVMASK;
    e.mvy = by & MVMASK;
    sb.push_back(e);
  endtask

  task automatic run(input string tag, input bit early, input bit pulses, output int lat);
    exp_t e;
    bit done = 1'b0;
    model_push();
    @(negedge clk);
    bus.start_signal = 1'b1;
    bus.early_term_en = early;
    @(negedge clk);
    bus.start_signal = 1'b0;
    bus.early_term_en = ~early;
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!done && lat < LAT + 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.process_completed === 1'b1) done = 1'b1;
      else if (pulses) bus.start_signal = (lat % 40 == 7);
    end
    bus.start_signal = 1'b0;
    chk({tag, ".done_seen"}, 32'(done), 32'd1);
    e = sb.pop_front();
    if (done) begin
      chk({tag, ".best"}, 32'(bus.best_distance), 32'(e.best));
      chk({tag, ".mvx"}, 32'(bus.motion_vector_x), 32'(e.mvx));
      chk({tag, ".mvy"}, 32'(bus.motion_vector_y), 32'(e.mvy));
      chk({tag, ".busy_in_done"}, 32'(bus.busy), 32'd0);
    end
    @(posedge clk);
    #1;
    chk({tag, ".pulse_len"}, 32'(bus.process_completed), 32'd0);
    chk({tag, ".idle_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    bus.start_signal = 1'b0;
    bus.early_term_en = 1'b0;
    for (int i = 0; i < BLK * BLK; i++) ref_mem[i] = '0;
    for (int i = 0; i < SW * SW; i++) srch_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.process_completed), 32'd0);
    chk("rst.best", 32'(bus.best_distance), 32'hFF);
    chk("rst.mvx", 32'(bus.motion_vector_x), 32'd0);
    chk("rst.mvy", 32'(bus.motion_vector_y), 32'd0);
    chk("rst.aref", 32'(bus.address_ref), 32'd0);
    chk("rst.asrc", 32'(bus.address_search), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reference block cut from the window at dx=+1, dy=-2.
    for (int i = 0; i < SW * SW; i++) srch_mem[i] = PIX_W'($urandom_range(0, 15));
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        ref_mem[r*BLK+c] = srch_mem[(0 + r)*SW + 3 + c];
    run("embed_exh", 1'b0, 1'b0, lat);
    chk("embed_exh.lat", 32'(lat), 32'(LAT));
    chk("embed_exh.mvx_const", 32'(bus.motion_vector_x), 32'b01);
    chk("embed_exh.mvy_const", 32'(bus.motion_vector_y), 32'b10);
    chk("embed_exh.best_const", 32'(bus.best_distance), 32'd0);
    run("embed_early", 1'b1, 1'b0, lat);
    chk("embed_early.faster", 32'(lat < LAT), 32'd1);

    for (int i = 0; i < BLK * BLK; i++) ref_mem[i] = PIX_W'($urandom_range(0, 15));
    run("rand_exh", 1'b0, 1'b0, lat);
    chk("rand_exh.lat", 32'(lat), 32'(LAT));
    run("rand_early", 1'b1, 1'b0, lat);
    chk("rand_early.bound", 32'(lat <= LAT), 32'd1);

    for (int i = 0; i < BLK * BLK; i++) ref_mem[i] = 8'hFF;
    for (int i = 0; i < SW * SW; i++) srch_mem[i] = 8'h00;
    run("sat_exh", 1'b0, 1'b0, lat);
    chk("sat_exh.lat", 32'(lat), 32'(LAT));
    run("sat_early", 1'b1, 1'b0, lat);
    chk("sat_early.faster", 32'(lat < LAT), 32'd1);

    for (int i = 0; i < BLK * BLK; i++) ref_mem[i] = 8'h40;
    for (int i = 0; i < SW * SW; i++) srch_mem[i] = 8'h40;
    run("flat_exh", 1'b0, 1'b0, lat);
    chk("flat_exh.lat", 32'(lat), 32'(LAT));
    chk("flat_exh.mvx_const", 32'(bus.motion_vector_x), 32'b10);
    chk("flat_exh.mvy_const", 32'(bus.motion_vector_y), 32'b10);

    // Abort a run part way; outputs must fall back to reset values.
    @(negedge clk);
    bus.start_signal = 1'b1;
    @(negedge clk);
    bus.start_signal = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.best", 32'(bus.best_distance), 32'hFF);
    chk("midrst.mvx", 32'(bus.motion_vector_x), 32'd0);
    chk("midrst.mvy", 32'(bus.motion_vector_y), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run("fresh_pulsed", 1'b0, 1'b1, lat);
    chk("fresh_pulsed.lat", 32'(lat), 32'(LAT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
